// File: rtl/deserializer_5bit.sv
// deserializer_5bit: MSB-first serial-to-parallel receiver with 2-entry valid/ready output buffer.
// Optional even-parity frame checking is enabled by defining SERDES_PARITY_EN.
module deserializer_5bit #(
    parameter int DATA_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_i,
    input  logic              frame_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              overflow_o,
    output logic              parity_err_o
);
    localparam int CW = $clog2(DATA_W);
`ifdef SERDES_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_sreg, w_word;
    logic [DATA_W-1:0] r_mem [2];
    logic              r_rd, r_wr, r_ovf, r_perr;
    logic [1:0]        r_count;
    logic              w_push, w_perr, w_pop, w_full, w_wr;
    assign w_pop  = (r_count != 2'd0) && ready_i;
    assign w_full = (r_count == 2'd2);
    assign w_wr   = w_push && (!w_full || w_pop);
    // state register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    // next-state, completed word and push/parity-error decisions
    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        w_perr = 1'b0;
        w_word = {r_sreg[DATA_W-2:0], serial_i};
        case (r_state)
            IDLE: w_next = frame_i ? SHIFT : IDLE;
            SHIFT: begin
                if (r_cnt == CW'(DATA_W-1)) begin
`ifdef SERDES_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = IDLE;
                    w_push = 1'b1;
`endif
                end
            end
`ifdef SERDES_PARITY_EN
            PARITY: begin
                w_next = IDLE;
                w_word = r_sreg;
                w_push = ~(^r_sreg ^ serial_i);
                w_perr = ^r_sreg ^ serial_i;
            end
`endif
            default: w_next = IDLE;
        endcase
    end
    // shift register and bit counter; MSB is loaded low and shifted up to the top
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (r_state == IDLE) begin
            if (frame_i) begin
                r_sreg <= {{(DATA_W-1){1'b0}}, serial_i};
                r_cnt  <= CW'(1);
            end
        end else if (r_state == SHIFT) begin
            r_sreg <= {r_sreg[DATA_W-2:0], serial_i};
            r_cnt  <= (r_cnt == CW'(DATA_W-1)) ? '0 : r_cnt + CW'(1);
        end
    end
    // 2-entry output FIFO plus registered overflow/parity-error pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_count  <= 2'd0;
            r_ovf    <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= w_word;
                r_wr        <= ~r_wr;
            end
            if (w_pop) r_rd <= ~r_rd;
            r_count <= r_count + {1'b0, w_wr} - {1'b0, w_pop};
            r_ovf   <= w_push && w_full && !w_pop;
            r_perr  <= w_perr;
        end
    end
    assign data_o       = r_mem[r_rd];
    assign valid_o      = (r_count != 2'd0);
    assign busy_o       = (r_state != IDLE);
    assign overflow_o   = r_ovf;
    assign parity_err_o = r_perr;
endmodule

// File: tb/tb_deserializer_5bit.sv
// tb_deserializer_5bit: directed self-checking bench for deserializer_5bit (honours SERDES_PARITY_EN).
module tb_deserializer_5bit;
`ifdef SERDES_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       serial_i = 1'b0;
    logic       frame_i = 1'b0;
    logic       ready_i = 1'b0;
    logic [4:0] data_o;
    logic       valid_o, busy_o, overflow_o, parity_err_o;
    int         checks = 0;
    int         failures = 0;

    deserializer_5bit #(.DATA_W(5)) dut (
        .clk(clk), .reset(reset), .serial_i(serial_i), .frame_i(frame_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o),
        .overflow_o(overflow_o), .parity_err_o(parity_err_o)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drives one frame (payload w, parity p when enabled), extra strobes on payload bits in xf,
    // optionally raises ready_i in the last bit cycle. Returns at the negedge after the last sample.
    task automatic send(input logic [4:0] w, input logic p, input logic chk_v,
                        input logic rdy_last, input logic [4:0] xf);
        logic [5:0] b;
        logic [5:0] x;
        b = {w, p};
        x = {xf, 1'b0};
        for (int k = 5; k >= 1 - PB; k--) begin
            @(negedge clk);
            if (k != 5) begin
                chk("busy_mid", {15'd0, busy_o}, 16'd1);
                if (chk_v) chk("valid_early", {15'd0, valid_o}, 16'd0);
            end
            frame_i  = (k == 5) || x[k];
            serial_i = b[k];
            if (rdy_last && k == 1 - PB) ready_i = 1'b1;
        end
        @(negedge clk);
        frame_i  = 1'b0;
        serial_i = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_data", {11'd0, data_o}, 16'h00);
        chk("rst_valid", {15'd0, valid_o}, 16'd0);
        chk("rst_busy", {15'd0, busy_o}, 16'd0);
        chk("rst_ovf", {15'd0, overflow_o}, 16'd0);
        chk("rst_perr", {15'd0, parity_err_o}, 16'd0);
        reset = 1'b1;
        // 1: single word with consumer ready
        ready_i = 1'b1;
        send(5'b10110, ^5'b10110, 1'b1, 1'b0, 5'd0);
        chk("t1_valid", {15'd0, valid_o}, 16'd1);
        chk("t1_data", {11'd0, data_o}, 16'h16);
        chk("t1_busy", {15'd0, busy_o}, 16'd0);
        @(negedge clk);
        chk("t1_valid_drop", {15'd0, valid_o}, 16'd0);
        // 2: fill buffer, third word overflows, then drain
        ready_i = 1'b0;
        send(5'h1F, ^5'h1F, 1'b1, 1'b0, 5'd0);
        chk("t2_v1", {15'd0, valid_o}, 16'd1);
        chk("t2_d1", {11'd0, data_o}, 16'h1F);
        send(5'h00, ^5'h00, 1'b0, 1'b0, 5'd0);
        chk("t2_d2", {11'd0, data_o}, 16'h1F);
        chk("t2_ovf0", {15'd0, overflow_o}, 16'd0);
        send(5'h15, ^5'h15, 1'b0, 1'b0, 5'd0);
        chk("t2_ovf", {15'd0, overflow_o}, 16'd1);
        chk("t2_hold", {11'd0, data_o}, 16'h1F);
        @(negedge clk);
        chk("t2_ovf_pulse", {15'd0, overflow_o}, 16'd0);
        chk("t2_stable", {11'd0, data_o}, 16'h1F);
        ready_i = 1'b1;
        @(negedge clk);
        chk("t2_pop1", {11'd0, data_o}, 16'h00);
        chk("t2_pop1_v", {15'd0, valid_o}, 16'd1);
        @(negedge clk);
        chk("t2_empty", {15'd0, valid_o}, 16'd0);
        // 3: full buffer with pop coinciding with push
        ready_i = 1'b0;
        send(5'h1F, ^5'h1F, 1'b1, 1'b0, 5'd0);
        send(5'h00, ^5'h00, 1'b0, 1'b0, 5'd0);
        chk("t3_head", {11'd0, data_o}, 16'h1F);
        send(5'h15, ^5'h15, 1'b0, 1'b1, 5'd0);
        chk("t3_no_ovf", {15'd0, overflow_o}, 16'd0);
        chk("t3_d2", {11'd0, data_o}, 16'h00);
        @(negedge clk);
        chk("t3_d3", {11'd0, data_o}, 16'h15);
        chk("t3_v3", {15'd0, valid_o}, 16'd1);
        @(negedge clk);
        chk("t3_empty", {15'd0, valid_o}, 16'd0);
        // 4: reset mid-frame with one word buffered
        ready_i = 1'b0;
        send(5'h1F, ^5'h1F, 1'b1, 1'b0, 5'd0);
        @(negedge clk); frame_i = 1'b1; serial_i = 1'b1;
        @(negedge clk); frame_i = 1'b0; serial_i = 1'b0;
        @(negedge clk); serial_i = 1'b1; reset = 1'b0;
        @(negedge clk);
        chk("t4_valid", {15'd0, valid_o}, 16'd0);
        chk("t4_data", {11'd0, data_o}, 16'h00);
        chk("t4_busy", {15'd0, busy_o}, 16'd0);
        chk("t4_ovf", {15'd0, overflow_o}, 16'd0);
        chk("t4_perr", {15'd0, parity_err_o}, 16'd0);
        reset = 1'b1; serial_i = 1'b0;
        send(5'h0A, ^5'h0A, 1'b1, 1'b0, 5'd0);
        chk("t4_v", {15'd0, valid_o}, 16'd1);
        chk("t4_word", {11'd0, data_o}, 16'h0A);
        ready_i = 1'b1;
        @(negedge clk);
        chk("t4_empty", {15'd0, valid_o}, 16'd0);
        // 5: extra frame strobes mid-frame are ignored
        send(5'b11001, ^5'b11001, 1'b1, 1'b0, 5'b00101);
        chk("t5_v", {15'd0, valid_o}, 16'd1);
        chk("t5_word", {11'd0, data_o}, 16'h19);
        @(negedge clk);
        chk("t5_empty", {15'd0, valid_o}, 16'd0);
        chk("t5_idle", {15'd0, busy_o}, 16'd0);
`ifdef SERDES_PARITY_EN
        // 6: parity good then bad
        send(5'b10110, 1'b1, 1'b1, 1'b0, 5'd0);
        chk("t6_v", {15'd0, valid_o}, 16'd1);
        chk("t6_word", {11'd0, data_o}, 16'h16);
        chk("t6_perr0", {15'd0, parity_err_o}, 16'd0);
        @(negedge clk);
        send(5'b10110, 1'b0, 1'b1, 1'b0, 5'd0);
        chk("t6_perr", {15'd0, parity_err_o}, 16'd1);
        chk("t6_nov", {15'd0, valid_o}, 16'd0);
        @(negedge clk);
        chk("t6_perr_pulse", {15'd0, parity_err_o}, 16'd0);
        chk("t6_nov2", {15'd0, valid_o}, 16'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
